decoder_alu_seq: RTL and testbench

Multi-cycle sequencer for the eight accumulator ALU operations (ADD/ADC/SUB/SBC/AND/XOR/OR/CP) in register, (HL) and immediate forms. It sits between the instruction table latch and the ALU/flag datapath. It accepts one opcode per handshake, fetches a memory or immediate operand over a byte-wide read handshake when required, and issues a one-cycle execute strobe with one-hot op select, flag-group select and accumulator write enable. It is parametrised for 8- or 16-bit operand width; in 16-bit mode, memory operands are assembled from two byte beats.

---
 rtl/decoder_alu_seq.sv | 136 +++++++++++++
 tb/tb_decoder_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_alu_seq.sv
// Multi-cycle sequencer for the eight accumulator ALU operations.
// Accepts one opcode per handshake, fetches an (HL) or immediate operand
// byte by byte when needed, then issues a one-cycle execute strobe.
module decoder_alu_seq #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              notReset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [7:0]        ITABLE,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic [2:0]        src_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_go,
  output logic [7:0]        alu_op,
  output logic [3:0]        flag_grp,
  output logic              write_a,
  output logic              illegal,
  output logic              busy
);

  localparam int NBEATS = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [1:0]          beat_q, beat_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic                illegal_q, illegal_d;

  logic                is_reg_form;
  logic                is_fetch_form;
  logic [2:0]          op_idx;

  // Classify the opcode byte currently offered on ITABLE.
  always_comb begin
    is_reg_form   = (ITABLE[7:6] == 2'b10) && (ITABLE[2:0] != 3'b110);
    is_fetch_form = ITABLE[7] && (ITABLE[2:0] == 3'b110);
  end

  // Next-state logic: acceptance, operand byte assembly and the execute step.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    beat_d    = beat_q;
    operand_d = operand_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          opcode_d = ITABLE;
          if (is_reg_form) begin
            state_d = EXEC;
          end else if (is_fetch_form) begin
            state_d = FETCH;
            beat_d  = 2'd0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (rd_ack) begin
          for (int i = 0; i < NBEATS; i++) begin
            if (beat_q == 2'(i)) begin
              operand_d[i*8 +: 8] = rd_data;
            end
          end
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'(NBEATS - 1)) begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset clearing everything.
  always_ff @(posedge CLK) begin
    if (!notReset) begin
      state_q   <= IDLE;
      opcode_q  <= 8'd0;
      beat_q    <= 2'd0;
      operand_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      beat_q    <= beat_d;
      operand_q <= operand_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode from registered state; only alu_b passes reg_data through.
  always_comb begin
    op_idx   = opcode_q[5:3];
    op_ready = (state_q == IDLE);
    rd_req   = (state_q == FETCH);
    alu_go   = (state_q == EXEC);
    busy     = (state_q != IDLE);
    illegal  = illegal_q;
    src_sel  = opcode_q[2:0];
    alu_op   = 8'd0;
    flag_grp = 4'd0;
    write_a  = 1'b0;
    alu_b    = '0;
    if (state_q == EXEC) begin
      alu_op  = 8'd1 << op_idx;
      write_a = (op_idx != 3'd7);
      alu_b   = (opcode_q[2:0] == 3'b110) ? operand_q : reg_data;
      case (op_idx)
        3'd0, 3'd1:       flag_grp = 4'b0001;
        3'd2, 3'd3, 3'd7: flag_grp = 4'b0010;
        3'd4:             flag_grp = 4'b0100;
        default:          flag_grp = 4'b1000;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_alu_seq.sv
// Scoreboard bench for decoder_alu_seq in 16-bit mode: the driver pushes the
// expected response of each accepted opcode, the monitor pops and compares
// whenever the DUT presents alu_go or illegal.
module tb_decoder_alu_seq;

  localparam int DATA_W = 16;
  localparam int NB     = DATA_W / 8;

  logic              CLK;
  logic              notReset;
  logic              op_valid;
  logic              op_ready;
  logic [7:0]        ITABLE;
  logic              rd_req;
  logic              rd_ack;
  logic [7:0]        rd_data;
  logic [2:0]        src_sel;
  logic [DATA_W-1:0] reg_data;
  logic [DATA_W-1:0] alu_b;
  logic              alu_go;
  logic [7:0]        alu_op;
  logic [3:0]        flag_grp;
  logic              write_a;
  logic              illegal;
  logic              busy;

  typedef struct {
    logic              ill;
    logic [7:0]        op;
    logic [3:0]        fg;
    logic              wa;
    logic [DATA_W-1:0] b;
    logic [2:0]        src;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 0;

  decoder_alu_seq #(.DATA_W(DATA_W)) dut (
    .CLK(CLK), .notReset(notReset), .op_valid(op_valid), .op_ready(op_ready),
    .ITABLE(ITABLE), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .src_sel(src_sel), .reg_data(reg_data), .alu_b(alu_b), .alu_go(alu_go),
    .alu_op(alu_op), .flag_grp(flag_grp), .write_a(write_a),
    .illegal(illegal), .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: 0 = register form, 1 = (HL)/immediate form, 2 = not an ALU form
  function automatic int formOf(input logic [7:0] opc);
    int hi, lo;
    hi = int'(opc) / 64;
    lo = int'(opc) % 8;
    if (hi == 2 && lo != 6) return 0;
    if (hi >= 2 && lo == 6) return 1;
    return 2;
  endfunction

  // Flag group per operation: ADD/ADC add-type, SUB/SBC/CP sub-type, AND, XOR/OR or-type
  function automatic logic [3:0] fgOf(input int ooo);
    case (ooo)
      0, 1:    return 4'b0001;
      2, 3, 7: return 4'b0010;
      4:       return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Offer an opcode until accepted; junk on rd_ack/rd_data must be ignored meanwhile.
  task automatic sendOpcode(input logic [7:0] opc, output int acc_cyc, output bit ok);
    bit rdy;
    int n;
    ITABLE   = opc;
    op_valid = 1'b1;
    rd_ack   = 1'($urandom % 2);
    rd_data  = 8'($urandom);
    n = 0;
    rdy = 1'b0;
    do begin
      @(negedge CLK);
      rdy = op_ready;
      @(posedge CLK);
      n++;
    end while (!rdy && n < 50);
    #1;
    op_valid = 1'b0;
    rd_ack   = 1'b0;
    acc_cyc  = cyc;
    ok = rdy;
    if (!rdy) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: opcode 0x%0h never accepted (op_ready=%0b, required 1)", opc, op_ready);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] opc, input logic [DATA_W-1:0] regv,
                               input logic [DATA_W-1:0] operand, input int w0, input int w1,
                               output int acc_cyc);
    int   form, ooo, w;
    bit   ok;
    exp_t e;
    reg_data = regv;
    sendOpcode(opc, acc_cyc, ok);
    if (!ok) return;
    form  = formOf(opc);
    ooo   = (int'(opc) / 8) % 8;
    e.ill = (form == 2);
    e.op  = (form == 2) ? 8'd0 : 8'(1 << ooo);
    e.fg  = fgOf(ooo);
    e.wa  = (ooo != 7);
    e.src = 3'(int'(opc) % 8);
    e.b   = (form == 0) ? regv : operand;
    e.cyc = acc_cyc + ((form == 1) ? (w0 + 1) + (NB - 1) * (w1 + 1) : 0);
    exp_q.push_back(e);
    if (form == 1) begin
      for (int i = 0; i < NB; i++) begin
        w = (i == 0) ? w0 : w1;
        for (int k = 0; k < w; k++) begin
          rd_ack  = 1'b0;
          rd_data = 8'($urandom);
          reg_data = DATA_W'($urandom);
          checkOutput("rd_req_wait", 32'(rd_req), 32'd1);
          @(posedge CLK);
          #1;
        end
        rd_ack  = 1'b1;
        rd_data = operand[i*8 +: 8];
        checkOutput("rd_req_beat", 32'(rd_req), 32'd1);
        @(posedge CLK);
        #1;
        rd_ack = 1'b0;
      end
    end else if (form == 0) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: pop one expectation per alu_go or illegal pulse; idle outputs must be zero.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (!alu_go) begin
        checkOutput("idle_outputs_zero", 32'({alu_op, flag_grp, write_a, alu_b}), 32'd0);
      end
      if (alu_go || illegal) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: alu_go=%0b illegal=%0b with nothing pending (required none)", alu_go, illegal);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("out_cycle", 32'(cyc), 32'(mon_e.cyc));
          if (mon_e.ill) begin
            checkOutput("illegal", 32'(illegal), 32'd1);
            checkOutput("illegal_alu_go", 32'(alu_go), 32'd0);
            checkOutput("illegal_rd_req", 32'(rd_req), 32'd0);
            checkOutput("illegal_op_ready", 32'(op_ready), 32'd1);
          end else begin
            checkOutput("alu_go", 32'(alu_go), 32'd1);
            checkOutput("exec_illegal", 32'(illegal), 32'd0);
            checkOutput("alu_op", 32'(alu_op), 32'(mon_e.op));
            checkOutput("flag_grp", 32'(flag_grp), 32'(mon_e.fg));
            checkOutput("write_a", 32'(write_a), 32'(mon_e.wa));
            checkOutput("alu_b", 32'(alu_b), 32'(mon_e.b));
            checkOutput("src_sel", 32'(src_sel), 32'(mon_e.src));
          end
        end
      end
    end
  end

  initial begin
    int          acc;
    int          b2b[4];
    logic [7:0]  b2b_ops[4];
    logic [7:0]  opc;
    logic [2:0]  ooo, sss;
    int          n;

    notReset = 1'b0;
    op_valid = 1'b0;
    ITABLE   = 8'd0;
    rd_ack   = 1'b0;
    rd_data  = 8'd0;
    reg_data = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset_op_ready", 32'(op_ready), 32'd1);
    checkOutput("reset_ctrl_zero", 32'({rd_req, alu_go, illegal, busy, src_sel, alu_op, flag_grp, write_a}), 32'd0);
    checkOutput("reset_alu_b", 32'(alu_b), 32'd0);
    notReset = 1'b1;
    @(posedge CLK);
    #1;
    mon_en = 1'b1;

    $display("[TB] ADD A,B register form");
    applyStimulus(8'h80, 16'h005A, 16'h0000, 0, 0, acc);
    checkOutput("add_ready_T2", 32'(op_ready), 32'd1);

    $display("[TB] CP n with two wait cycles on the first beat");
    applyStimulus(8'hFE, 16'hBEEF, 16'h1242, 2, 0, acc);

    $display("[TB] AND (HL) with back-to-back beats");
    applyStimulus(8'hA6, 16'hCAFE, 16'h1234, 0, 0, acc);

    $display("[TB] non-ALU opcode then OR B");
    applyStimulus(8'h3E, 16'h0000, 16'h0000, 0, 0, acc);
    checkOutput("illegal_no_busy", 32'(busy), 32'd0);
    applyStimulus(8'hB0, 16'h0F0F, 16'h0000, 0, 0, acc);

    $display("[TB] reset in the second FETCH cycle of SUB n");
    sendOpcode(8'hD6, acc, n[0]);
    rd_ack  = 1'b1;
    rd_data = 8'h77;
    @(posedge CLK);
    #1;
    rd_ack   = 1'b0;
    notReset = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("midfetch_rd_req", 32'(rd_req), 32'd0);
    checkOutput("midfetch_busy", 32'(busy), 32'd0);
    checkOutput("midfetch_op_ready", 32'(op_ready), 32'd1);
    checkOutput("midfetch_zero", 32'({alu_go, illegal, src_sel, alu_op, flag_grp, write_a, alu_b}), 32'd0);
    notReset = 1'b1;
    applyStimulus(8'h88, 16'h3C3C, 16'h0000, 0, 0, acc);

    $display("[TB] back-to-back register forms");
    b2b_ops[0] = 8'h90;
    b2b_ops[1] = 8'h98;
    b2b_ops[2] = 8'hA8;
    b2b_ops[3] = 8'hB8;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(b2b_ops[i], DATA_W'($urandom), 16'h0000, 0, 0, b2b[i]);
    end
    for (int i = 1; i < 4; i++) begin
      checkOutput("b2b_spacing", 32'(b2b[i] - b2b[i-1]), 32'd2);
    end

    $display("[TB] randomized opcodes");
    for (int i = 0; i < 80; i++) begin
      ooo = 3'($urandom);
      sss = 3'($urandom);
      case ($urandom % 4)
        0, 1: begin
          if (sss == 3'b110) sss = 3'b111;
          opc = {2'b10, ooo, sss};
        end
        2: opc = {1'b1, 1'($urandom), ooo, 3'b110};
        default: opc = 8'($urandom);
      endcase
      applyStimulus(opc, DATA_W'($urandom), DATA_W'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), acc);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge CLK);
      n++;
    end
    @(negedge CLK);
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_output: expected alu_op 0x%0h illegal %0b at cycle %0d, got nothing", mon_e.op, mon_e.ill, mon_e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
